// File: rtl/eeg_frame_deserializer.sv
// Bit-serial EEG frame capture: synchronizes chip-side din/data_clk/data_trig and packs frames into 16-bit words.
// Define EEG_DESER_HDR_EN to prefix every frame with a {8'hA5, frame_cnt[7:0]} header word.
module eeg_frame_deserializer #(
    parameter int FRAME_BITS  = 20,
    parameter int SYNC_STAGES = 2
) (
    input  logic        sys_clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        din,
    input  logic        data_clk,
    input  logic        data_trig,
    output logic [15:0] word_data,
    output logic        word_valid,
    input  logic        word_ready,
    output logic [15:0] frame_cnt,
    output logic [15:0] drop_cnt,
    output logic [7:0]  short_cnt,
    output logic        overflow
);

    localparam bit         HAS_HI   = (FRAME_BITS > 16);
    localparam logic [5:0] LAST_BIT = 6'(FRAME_BITS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CAPTURE,
`ifdef EEG_DESER_HDR_EN
        S_HDR,
`endif
        S_EMIT_HI,
        S_EMIT_LO
    } state_t;

    localparam state_t FIRST_DATA = HAS_HI ? S_EMIT_HI : S_EMIT_LO;
`ifdef EEG_DESER_HDR_EN
    localparam state_t FIRST_WORD = S_HDR;
`else
    localparam state_t FIRST_WORD = FIRST_DATA;
`endif

    logic [SYNC_STAGES-1:0] din_sync_q, clk_sync_q, trig_sync_q;
    logic                   clk_prev_q, trig_prev_q;
    logic                   din_s, clk_s, trig_s, bit_stb, trig_stb;

    state_t      state_q, state_d;
    logic [31:0] shreg_q, shreg_d;
    logic [5:0]  bitcnt_q, bitcnt_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic [15:0] drop_cnt_q, drop_cnt_d;
    logic [7:0]  short_cnt_q, short_cnt_d;
    logic        overflow_q, overflow_d;
    logic [15:0] word_data_q, word_data_d;
    logic        word_valid_q, word_valid_d;
    logic        accept, drop_ev;

    assign din_s    = din_sync_q[SYNC_STAGES-1];
    assign clk_s    = clk_sync_q[SYNC_STAGES-1];
    assign trig_s   = trig_sync_q[SYNC_STAGES-1];
    assign bit_stb  = clk_s & ~clk_prev_q;
    assign trig_stb = trig_s & ~trig_prev_q;
    assign accept   = word_valid_q & word_ready;

    function automatic logic [15:0] word_for(state_t s, logic [31:0] sh, logic [15:0] fc);
        logic [15:0] w;
        w = 16'h0000;
        case (s)
`ifdef EEG_DESER_HDR_EN
            S_HDR:     w = {8'hA5, fc[7:0]};
`endif
            S_EMIT_HI: w = sh[31:16];
            S_EMIT_LO: w = sh[15:0];
            default:   w = 16'h0000;
        endcase
        return w;
    endfunction

    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        bitcnt_d    = bitcnt_q;
        frame_cnt_d = frame_cnt_q;
        drop_cnt_d  = drop_cnt_q;
        short_cnt_d = short_cnt_q;
        overflow_d  = overflow_q;
        drop_ev     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (trig_stb && enable) begin
                    shreg_d  = '0;
                    bitcnt_d = '0;
                    state_d  = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                // Final bit wins over a coincident trigger, which then counts as a drop
                if (bit_stb && (bitcnt_q + 6'd1 == LAST_BIT)) begin
                    shreg_d     = {shreg_q[30:0], din_s};
                    bitcnt_d    = bitcnt_q + 6'd1;
                    frame_cnt_d = frame_cnt_q + 16'd1;
                    state_d     = FIRST_WORD;
                    drop_ev     = trig_stb;
                end else if (trig_stb) begin
                    shreg_d     = '0;
                    bitcnt_d    = '0;
                    short_cnt_d = (short_cnt_q == 8'hFF) ? short_cnt_q : short_cnt_q + 8'd1;
                end else if (bit_stb) begin
                    shreg_d  = {shreg_q[30:0], din_s};
                    bitcnt_d = bitcnt_q + 6'd1;
                end
            end
`ifdef EEG_DESER_HDR_EN
            S_HDR: begin
                drop_ev = trig_stb;
                if (accept) state_d = FIRST_DATA;
            end
`endif
            S_EMIT_HI: begin
                drop_ev = trig_stb;
                if (accept) state_d = S_EMIT_LO;
            end
            S_EMIT_LO: begin
                drop_ev = trig_stb;
                if (accept) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (drop_ev) begin
            drop_cnt_d = (drop_cnt_q == 16'hFFFF) ? drop_cnt_q : drop_cnt_q + 16'd1;
            overflow_d = 1'b1;
        end
        word_valid_d = (state_d != S_IDLE) && (state_d != S_CAPTURE);
        word_data_d  = word_for(state_d, shreg_d, frame_cnt_d);
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            din_sync_q   <= '0;
            clk_sync_q   <= '0;
            trig_sync_q  <= '0;
            clk_prev_q   <= 1'b0;
            trig_prev_q  <= 1'b0;
            state_q      <= S_IDLE;
            shreg_q      <= '0;
            bitcnt_q     <= '0;
            frame_cnt_q  <= '0;
            drop_cnt_q   <= '0;
            short_cnt_q  <= '0;
            overflow_q   <= 1'b0;
            word_data_q  <= '0;
            word_valid_q <= 1'b0;
        end else begin
            din_sync_q   <= {din_sync_q[SYNC_STAGES-2:0], din};
            clk_sync_q   <= {clk_sync_q[SYNC_STAGES-2:0], data_clk};
            trig_sync_q  <= {trig_sync_q[SYNC_STAGES-2:0], data_trig};
            clk_prev_q   <= clk_s;
            trig_prev_q  <= trig_s;
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            bitcnt_q     <= bitcnt_d;
            frame_cnt_q  <= frame_cnt_d;
            drop_cnt_q   <= drop_cnt_d;
            short_cnt_q  <= short_cnt_d;
            overflow_q   <= overflow_d;
            word_data_q  <= word_data_d;
            word_valid_q <= word_valid_d;
        end
    end

    assign word_data  = word_data_q;
    assign word_valid = word_valid_q;
    assign frame_cnt  = frame_cnt_q;
    assign drop_cnt   = drop_cnt_q;
    assign short_cnt  = short_cnt_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_eeg_frame_deserializer.sv
// Bench for eeg_frame_deserializer: frame-level word/counter model, directed plan cases, then random traffic.
module tb_eeg_frame_deserializer;

    localparam int FB = 20;
    localparam int SS = 2;

    logic        sys_clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b1;
    logic        din = 1'b0;
    logic        data_clk = 1'b0;
    logic        data_trig = 1'b0;
    logic        word_ready = 1'b0;
    logic [15:0] word_data;
    logic        word_valid;
    logic [15:0] frame_cnt;
    logic [15:0] drop_cnt;
    logic [7:0]  short_cnt;
    logic        overflow;

    eeg_frame_deserializer #(.FRAME_BITS(FB), .SYNC_STAGES(SS)) dut (
        .sys_clk(sys_clk), .reset(reset), .enable(enable), .din(din),
        .data_clk(data_clk), .data_trig(data_trig),
        .word_data(word_data), .word_valid(word_valid), .word_ready(word_ready),
        .frame_cnt(frame_cnt), .drop_cnt(drop_cnt), .short_cnt(short_cnt),
        .overflow(overflow)
    );

    always #5 sys_clk = ~sys_clk;

    int          tests = 0;
    int          fails = 0;
    logic [15:0] expq[$];
    logic [15:0] wlog[$];
    logic [15:0] lit[$];
    int          m_frame, m_drop, m_short, m_nbits;
    bit          m_ovf, m_cap;
    logic [31:0] m_val;
    bit          in_rst = 1'b1;
    bit          hold = 1'b0;
    int          rmode = 1;
    int          nwrites = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(int n = 1);
        repeat (n) begin
            @(posedge sys_clk);
            #2;
        end
    endtask

    // ready: 0 random, 1 always high, 2 always low; hold forces low
    initial forever begin
        @(posedge sys_clk);
        #1;
        if (hold) word_ready = 1'b0;
        else if (rmode == 0) word_ready = 1'($urandom_range(0, 1));
        else word_ready = (rmode == 1);
    end

    logic        pv = 1'b0, pr = 1'b0;
    logic [15:0] pd = '0;
    initial forever begin
        @(negedge sys_clk);
        if (in_rst || reset) begin
            pv = 1'b0;
            pr = 1'b0;
        end else begin
            if (pv && !pr) begin
                chk("hold_valid", 32'(word_valid), 32'd1);
                chk("hold_data", 32'(word_data), 32'(pd));
            end
            if (word_valid) begin
                if (expq.size() == 0) chk("spurious_valid", 32'(word_valid), 32'd0);
                else if (word_ready) begin
                    chk("word", 32'(word_data), 32'(expq[0]));
                    void'(expq.pop_front());
                    wlog.push_back(word_data);
                    nwrites++;
                end
            end
            pv = word_valid;
            pr = word_ready;
            pd = word_data;
        end
    end

    task automatic m_push_frame();
        m_frame++;
`ifdef EEG_DESER_HDR_EN
        expq.push_back({8'hA5, 8'(m_frame)});
`endif
        if (FB > 16) expq.push_back(16'(m_val >> 16));
        expq.push_back(m_val[15:0]);
        m_cap = 1'b0;
    endtask

    task automatic send_bit(logic b);
        din = b;
        tick(2);
        data_clk = 1'b1;
        if (m_cap) begin
            m_val = {m_val[30:0], b};
            m_nbits++;
            if (m_nbits == FB) m_push_frame();
        end
        tick(4);
        data_clk = 1'b0;
        tick(4);
    endtask

    task automatic send_trig();
        hold = 1'b1;
        tick(2);
        if (expq.size() != 0) begin
            if (m_drop < 65535) m_drop++;
            m_ovf = 1'b1;
        end else if (m_cap) begin
            if (m_short < 255) m_short++;
            m_val = '0;
            m_nbits = 0;
        end else if (enable) begin
            m_cap = 1'b1;
            m_val = '0;
            m_nbits = 0;
        end
        data_trig = 1'b1;
        tick(5);
        data_trig = 1'b0;
        tick(5);
        hold = 1'b0;
    endtask

    task automatic send_frame(logic [31:0] v, int n);
        for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic do_reset();
        in_rst = 1'b1;
        reset = 1'b1;
        data_clk = 1'b0;
        data_trig = 1'b0;
        tick(3);
        expq.delete();
        m_frame = 0; m_drop = 0; m_short = 0; m_nbits = 0;
        m_ovf = 1'b0; m_cap = 1'b0; m_val = '0;
        reset = 1'b0;
        tick(1);
        in_rst = 1'b0;
    endtask

    task automatic drain(string name);
        int k;
        k = 0;
        while (expq.size() != 0 && k < 2000) begin
            tick(1);
            k++;
        end
        chk({name, "_drain"}, 32'(expq.size()), 32'd0);
        tick(3);
    endtask

    task automatic check_cnts(string name);
        chk({name, "_frame_cnt"}, 32'(frame_cnt), 32'(16'(m_frame)));
        chk({name, "_drop_cnt"}, 32'(drop_cnt), 32'(m_drop));
        chk({name, "_short_cnt"}, 32'(short_cnt), 32'(m_short));
        chk({name, "_overflow"}, 32'(overflow), 32'(m_ovf));
    endtask

    task automatic check_log(string name);
        chk({name, "_nwords"}, 32'(wlog.size()), 32'(lit.size()));
        for (int i = 0; i < lit.size() && i < wlog.size(); i++)
            chk({name, "_lit_word"}, 32'(wlog[i]), 32'(lit[i]));
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int k;
        int op;
        rmode = 1;
        do_reset();
        chk("rst_word_data", 32'(word_data), 32'd0);
        chk("rst_word_valid", 32'(word_valid), 32'd0);
        chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        chk("rst_drop_cnt", 32'(drop_cnt), 32'd0);
        chk("rst_short_cnt", 32'(short_cnt), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);

        wlog.delete();
        send_trig();
        send_frame(32'hABCDE, FB);
        drain("basic");
`ifdef EEG_DESER_HDR_EN
        lit = {16'hA501, 16'h000A, 16'hBCDE};
`else
        lit = {16'h000A, 16'hBCDE};
`endif
        check_log("basic");
        chk("basic_frame_lit", 32'(frame_cnt), 32'd1);
        check_cnts("basic");

        rmode = 2;
        wlog.delete();
        nwrites = 0;
        send_trig();
        send_frame(32'hABCDE, FB);
        k = 0;
        while (!word_valid && k < 100) begin
            tick(1);
            k++;
        end
        chk("bp_valid_seen", 32'(word_valid), 32'd1);
        tick(50);
        chk("bp_hold_valid", 32'(word_valid), 32'd1);
`ifdef EEG_DESER_HDR_EN
        chk("bp_hold_data", 32'(word_data), 32'h0000A502);
`else
        chk("bp_hold_data", 32'(word_data), 32'h0000000A);
`endif
        rmode = 1;
        drain("bp");
`ifdef EEG_DESER_HDR_EN
        chk("bp_writes", 32'(nwrites), 32'd3);
`else
        chk("bp_writes", 32'(nwrites), 32'd2);
`endif
        check_cnts("bp");

        rmode = 2;
        wlog.delete();
        send_trig();
        send_frame(32'h13579, FB);
        send_trig();
        send_frame(32'h2468A, FB);
        chk("drop_cnt_lit", 32'(drop_cnt), 32'd1);
        chk("drop_ovf_lit", 32'(overflow), 32'd1);
        rmode = 1;
        drain("drop");
`ifdef EEG_DESER_HDR_EN
        lit = {16'hA503, 16'h0001, 16'h3579};
`else
        lit = {16'h0001, 16'h3579};
`endif
        check_log("drop");
        check_cnts("drop");

        wlog.delete();
        send_trig();
        send_frame(32'h5A, 7);
        send_trig();
        send_frame(32'h12345, FB);
        drain("short");
`ifdef EEG_DESER_HDR_EN
        lit = {16'hA504, 16'h0001, 16'h2345};
`else
        lit = {16'h0001, 16'h2345};
`endif
        check_log("short");
        chk("short_cnt_lit", 32'(short_cnt), 32'd1);
        check_cnts("short");

        send_trig();
        send_frame(32'h3FF, 10);
        do_reset();
        wlog.delete();
        send_trig();
        send_frame(32'hFFFFF, FB);
        drain("midrst");
`ifdef EEG_DESER_HDR_EN
        lit = {16'hA501, 16'h000F, 16'hFFFF};
`else
        lit = {16'h000F, 16'hFFFF};
`endif
        check_log("midrst");
        chk("midrst_frame_lit", 32'(frame_cnt), 32'd1);
        check_cnts("midrst");

        enable = 1'b0;
        send_trig();
        send_frame(32'h55555, FB);
        tick(10);
        chk("en_low_frame_lit", 32'(frame_cnt), 32'd1);
        check_cnts("en_low");
        enable = 1'b1;

        do_reset();
        wlog.delete();
        send_trig();
        send_frame(32'h00001, FB);
        drain("two_a");
        send_trig();
        send_frame(32'h00001, FB);
        drain("two_b");
`ifdef EEG_DESER_HDR_EN
        lit = {16'hA501, 16'h0000, 16'h0001, 16'hA502, 16'h0000, 16'h0001};
`else
        lit = {16'h0000, 16'h0001, 16'h0000, 16'h0001};
`endif
        check_log("two");

        rmode = 0;
        for (int it = 0; it < 600; it++) begin
            op = int'($urandom_range(0, 29));
            if (op == 0) send_trig();
            else if (op == 1) rmode = int'($urandom_range(0, 2));
            else if (op == 2) enable = ~enable;
            else send_bit(1'($urandom_range(0, 1)));
            if (it % 50 == 49) check_cnts("rand");
        end
        rmode = 1;
        enable = 1'b1;
        drain("rand_end");
        check_cnts("rand_end");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/eeg_frame_deserializer.md
# eeg_frame_deserializer

Bit-serial front end that sits directly upstream of the NEXTOUT FIFO path in the ear-EEG acquisition top. It samples the chip's serial output (`din`) on the chip-side data clock (fdata), frames bits using the READ strobe, and packs each frame into 16-bit words. Words are presented on a valid/ready interface to the FIFO write side. All logic runs on `sys_clk`; the chip-side signals are asynchronous and are synchronized internally.

## Interface
Parameters:
- `FRAME_BITS`, default 20: bits per READ frame, legal range 1..32.
- `SYNC_STAGES`, default 2: synchronizer depth for `din`, `data_clk` and `data_trig`, legal range 2..3.

Ports:
- `sys_clk` in 1: system clock (200 MHz); the only clock.
- `reset` in 1: synchronous, active-high reset.
- `enable` in 1: capture enable. While low, new frames are not started; a word being emitted is allowed to finish.
- `din` in 1: serial data from the chip; asynchronous.
- `data_clk` in 1: chip bit clock (fdata); asynchronous; `din` is valid at its rising edge.
- `data_trig` in 1: READ strobe; asynchronous; its rising edge starts a frame.
- `word_data` out 16: packed word.
- `word_valid` out 1: `word_data` is valid.
- `word_ready` in 1: FIFO accepts the word (wr_en = valid & ready).
- `frame_cnt` out 16: number of completed frames; wraps.
- `drop_cnt` out 16: frames dropped because output was busy; saturates at 16'hFFFF.
- `short_cnt` out 8: frames aborted before all bits arrived; saturates at 8'hFF.
- `overflow` out 1: sticky; set on first drop; cleared only by `reset`.

## Operation
- `din`, `data_clk` and `data_trig` each pass through `SYNC_STAGES` flops. `din` uses the same depth so it stays aligned with `data_clk`.
- A rising-edge detect on the synchronized `data_clk` gives `bit_stb`; the same on synchronized `data_trig` gives `trig_stb`. Each is one cycle wide.
- States:
  - IDLE: on `trig_stb & enable`, clear the shift register and bit counter, then go to CAPTURE.
  - CAPTURE: on each `bit_stb`, do `shreg <= {shreg[30:0], din_s}` (MSB first) and `bitcnt++`.
    - When `bitcnt` reaches `FRAME_BITS`: increment `frame_cnt`, then go to HDR (macro on) or EMIT_HI / EMIT_LO (macro off).
    - On `trig_stb` before the frame completes: increment `short_cnt`, discard the partial frame and restart CAPTURE with cleared counters.
  - HDR: `word_data = {8'hA5, frame_cnt[7:0]}`, using the value after the increment. Advance on handshake.
  - EMIT_HI (only when `FRAME_BITS > 16`): `word_data = {zero-pad, frame[FRAME_BITS-1:16]}`, right-aligned.
  - EMIT_LO: `word_data = frame[15:0]`, zero-padded when `FRAME_BITS < 16`. On handshake, go to IDLE.
- Transition out of HDR and EMIT states:
  - Advance on `word_valid & word_ready`.
  - `word_data` and `word_valid` hold stable until accepted.
  - `word_valid` is never retracted while waiting.
- Once EMIT_LO completes, the next frame is accepted from IDLE.
- Events while in HDR/EMIT:
  - `bit_stb` is ignored.
  - `trig_stb` increments `drop_cnt` and sets `overflow`. The frame is not captured.
- Simultaneous `trig_stb` and the final `bit_stb` in CAPTURE: the frame completes first, and the trigger counts as a drop.
- `enable` low in IDLE: `trig_stb` is ignored and no counters change.
- `reset` mid-operation clears every state element at the next edge and abandons any pending word. No partial word is emitted.

## Timing
- Reset values: `word_data` = 0, `word_valid` = 0, `frame_cnt` = 0, `drop_cnt` = 0, `short_cnt` = 0, `overflow` = 0. State is IDLE and the synchronizers are cleared.
- Input to strobe: `SYNC_STAGES` + 1 cycles from a chip-side edge to `bit_stb` / `trig_stb`.
- Last-bit `bit_stb` to `word_valid` high: 1 cycle.
- Back-to-back accepts: one word per cycle when `word_ready` is held high.
- Chip-side requirement: `data_clk` high and low times ≥ `SYNC_STAGES` + 1 sys_clk periods. Faster clocks lose bits; this is not detected.
- All outputs are registered.

## Configuration
- `EEG_DESER_HDR_EN`:
  - Defined: every frame is preceded by one header word, `{8'hA5, frame_cnt[7:0]}`. Words per frame = 2 or 3.
  - Undefined: the HDR state is not compiled. Words per frame = 1 (`FRAME_BITS` ≤ 16) or 2.

## Test plan
- Reset, `FRAME_BITS` = 20, macro off: READ pulse, then 20 bits 0xABCDE MSB first, with `word_ready` = 1 → words 16'h000A then 16'hBCDE; `frame_cnt` = 1.
- Backpressure: `word_ready` = 0 for 50 cycles after valid → `word_data` stays 16'h000A with `word_valid` held high; after ready, exactly 2 writes occur.
- Drop: hold `word_ready` = 0 and issue a second READ plus 20 bits → `drop_cnt` = 1, `overflow` = 1; only the first frame's words are emitted.
- Short frame: READ, 7 bits, READ, 20 bits 0x12345 → `short_cnt` = 1; words 16'h0001 then 16'h2345.
- Reset mid-frame after 10 bits, then a full frame of 0xFFFFF → no stale word; words 16'h000F then 16'hFFFF; `frame_cnt` = 1.
- Macro on: two frames of 0x00001 → words A501, 0000, 0001, A502, 0000, 0001.
